// File: rtl/gtx_align_monitor_pkg.sv
// Shared definitions for the GTX multi-lane alignment monitor:
// lane FSM state encoding and the counter-width helper.
package gtx_align_pkg;

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_LOCKING  = 2'd1;
  localparam logic [1:0] ST_ALIGNED  = 2'd2;
  localparam logic [1:0] ST_REALIGN  = 2'd3;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/gtx_align_monitor_if.sv
// Status/strobe bundle between the GTX RX wrapper side (master) and the
// alignment monitor (slave).
interface gtx_align_if #(
  parameter int NLANES = 4,
  parameter int CW     = 8
) ();

  logic [NLANES-1:0]    comma_detected;
  logic [NLANES-1:0]    code_err;
  logic                 sticky_clear;
  logic [NLANES-1:0]    aligned;
  logic                 all_aligned;
  logic [NLANES-1:0]    realign_req;
  logic [NLANES-1:0]    loss_sticky;
  logic [NLANES*CW-1:0] loss_count;

  modport master (
    output comma_detected, code_err, sticky_clear,
    input  aligned, all_aligned, realign_req, loss_sticky, loss_count
  );

  modport slave (
    input  comma_detected, code_err, sticky_clear,
    output aligned, all_aligned, realign_req, loss_sticky, loss_count
  );

endinterface

// File: rtl/gtx_align_lane.sv
// One lane of byte-alignment qualification: lock/loss hysteresis FSM,
// timed realign request and saturating loss statistics.
module gtx_align_lane
  import gtx_align_pkg::*;
#(
  parameter int LOCK_THRESHOLD = 20,
  parameter int MISS_THRESHOLD = 1023,
  parameter int ERR_LIMIT      = 4,
  parameter int REALIGN_HOLD   = 16,
  parameter int CW             = 8
) (
  input  logic          ref_clk,
  input  logic          reset,
  input  logic          comma_detected,
  input  logic          code_err,
  input  logic          sticky_clear,
  output logic          aligned,
  output logic          realign_req,
  output logic          loss_sticky,
  output logic [CW-1:0] loss_count
);

  localparam int MISS_W  = cnt_width(MISS_THRESHOLD);
  localparam int COMMA_W = cnt_width(LOCK_THRESHOLD);
  localparam int ERR_W   = cnt_width(ERR_LIMIT);
  localparam int HOLD_W  = cnt_width(REALIGN_HOLD);

  localparam logic [MISS_W-1:0]  MISS_MAX   = MISS_W'(MISS_THRESHOLD);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(MISS_THRESHOLD - 1);
  localparam logic [COMMA_W-1:0] COMMA_ONE  = COMMA_W'(1);
  localparam logic [COMMA_W-1:0] COMMA_LAST = COMMA_W'(LOCK_THRESHOLD - 1);
  localparam logic [ERR_W-1:0]   ERR_MAX    = ERR_W'(ERR_LIMIT);
  localparam logic [ERR_W-1:0]   ERR_LAST   = ERR_W'(ERR_LIMIT - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(REALIGN_HOLD - 1);

  logic [1:0]         state_q, state_d;
  logic [MISS_W-1:0]  miss_q, miss_d, miss_next;
  logic [COMMA_W-1:0] comma_q, comma_d;
  logic [ERR_W-1:0]   err_q, err_d, err_next;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [CW-1:0]      loss_q, loss_d;
  logic               sticky_q, sticky_d;
  logic               clean_comma;
  logic               lost;

  // A comma coinciding with a code error is treated as an error only.
  assign clean_comma = comma_detected & ~code_err;

  always_comb begin
    miss_next = miss_q;
    if (comma_detected)        miss_next = '0;
    else if (miss_q != MISS_MAX) miss_next = miss_q + 1'b1;

    err_next = '0;
    if (code_err) err_next = (err_q != ERR_MAX) ? err_q + 1'b1 : err_q;

    state_d  = state_q;
    miss_d   = miss_next;
    err_d    = err_next;
    comma_d  = comma_q;
    hold_d   = hold_q;
    loss_d   = loss_q;
    sticky_d = sticky_q & ~sticky_clear;
    lost     = 1'b0;

    case (state_q)
      ST_UNLOCKED: begin
        if (clean_comma) state_d = (LOCK_THRESHOLD == 1) ? ST_ALIGNED : ST_LOCKING;
      end
      ST_LOCKING: begin
        if (code_err) begin
          state_d = ST_UNLOCKED;
        end else if (comma_detected) begin
          if (comma_q == COMMA_LAST) state_d = ST_ALIGNED;
          else                       comma_d = comma_q + 1'b1;
        end else if (miss_q == MISS_LAST) begin
          state_d = ST_UNLOCKED;
        end
      end
      ST_ALIGNED: begin
        if ((!comma_detected && miss_q == MISS_LAST) || (code_err && err_q == ERR_LAST)) begin
          state_d = ST_REALIGN;
          lost    = 1'b1;
        end
      end
      default: begin
        miss_d = '0;
        err_d  = '0;
        if (hold_q == HOLD_LAST) state_d = ST_UNLOCKED;
        else                     hold_d  = hold_q + 1'b1;
      end
    endcase

    // A new loss overrides a simultaneous sticky_clear.
    if (lost) begin
      sticky_d = 1'b1;
      if (loss_q != '1) loss_d = loss_q + 1'b1;
    end

    if (state_d != state_q) begin
      miss_d  = '0;
      err_d   = '0;
      hold_d  = '0;
      comma_d = (state_d == ST_LOCKING) ? COMMA_ONE : '0;
    end
  end

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state_q  <= ST_UNLOCKED;
      miss_q   <= '0;
      comma_q  <= '0;
      err_q    <= '0;
      hold_q   <= '0;
      loss_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      miss_q   <= miss_d;
      comma_q  <= comma_d;
      err_q    <= err_d;
      hold_q   <= hold_d;
      loss_q   <= loss_d;
      sticky_q <= sticky_d;
    end
  end

  assign aligned     = (state_q == ST_ALIGNED);
  assign realign_req = (state_q == ST_REALIGN);
  assign loss_sticky = sticky_q;
  assign loss_count  = loss_q;

endmodule

// File: rtl/gtx_align_monitor.sv
// Multi-lane GTX byte-alignment monitor: independent per-lane qualifiers
// plus a registered all-lanes-aligned flag.
module gtx_align_monitor
  import gtx_align_pkg::*;
#(
  parameter int NLANES         = 4,
  parameter int LOCK_THRESHOLD = 20,
  parameter int MISS_THRESHOLD = 1023,
  parameter int ERR_LIMIT      = 4,
  parameter int REALIGN_HOLD   = 16,
  parameter int CW             = 8
) (
  input logic        ref_clk,
  input logic        reset,
  gtx_align_if.slave bus
);

  logic [NLANES-1:0]    aligned_w;
  logic [NLANES-1:0]    realign_w;
  logic [NLANES-1:0]    sticky_w;
  logic [NLANES*CW-1:0] count_w;
  logic                 all_aligned_q, all_aligned_d;

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    gtx_align_lane #(
      .LOCK_THRESHOLD (LOCK_THRESHOLD),
      .MISS_THRESHOLD (MISS_THRESHOLD),
      .ERR_LIMIT      (ERR_LIMIT),
      .REALIGN_HOLD   (REALIGN_HOLD),
      .CW             (CW)
    ) u_lane (
      .ref_clk        (ref_clk),
      .reset          (reset),
      .comma_detected (bus.comma_detected[i]),
      .code_err       (bus.code_err[i]),
      .sticky_clear   (bus.sticky_clear),
      .aligned        (aligned_w[i]),
      .realign_req    (realign_w[i]),
      .loss_sticky    (sticky_w[i]),
      .loss_count     (count_w[i*CW +: CW])
    );
  end

  assign all_aligned_d = &aligned_w;

  always_ff @(posedge ref_clk) begin
    if (reset) all_aligned_q <= 1'b0;
    else       all_aligned_q <= all_aligned_d;
  end

  assign bus.aligned     = aligned_w;
  assign bus.realign_req = realign_w;
  assign bus.loss_sticky = sticky_w;
  assign bus.loss_count  = count_w;
  assign bus.all_aligned = all_aligned_q;

endmodule

// File: doc/gtx_align_monitor.md
# gtx_align_monitor

Multi-lane successor to the single-lane GTX byte-alignment detector: qualifies each transceiver lane's byte alignment from its comma-detect and code-error strobes, with lock/loss hysteresis and an explicit realign handshake toward the GTX. It also keeps per-lane loss statistics. It sits between the GTX wrapper RX status outputs and the cell-controller link logic and status registers, all in the `ref_clk` domain.

## Interface
- `NLANES`, 4, number of independent lanes (1..16)
- `LOCK_THRESHOLD`, 20, commas in `LOCKING` needed to declare alignment (1..255)
- `MISS_THRESHOLD`, 1023, consecutive comma-free cycles that declare loss or restart locking (1..65535)
- `ERR_LIMIT`, 4, consecutive code-error cycles in `ALIGNED` that declare loss (1..255)
- `REALIGN_HOLD`, 16, cycles `realign_req` is held after a loss (1..255)
- `CW`, 8, width of each loss-event counter
- `ref_clk` in 1: single clock. Reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high; returns every lane to `UNLOCKED` and clears all counters and flags
- `comma_detected` in NLANES: per-lane comma strobe, one cycle per comma
- `code_err` in NLANES: per-lane disparity/not-in-table error strobe
- `sticky_clear` in 1: one-cycle pulse that clears all `loss_sticky` bits
- `aligned` out NLANES: lane is in `ALIGNED`
- `all_aligned` out 1: registered AND of all `aligned` bits
- `realign_req` out NLANES: high while the lane is in `REALIGN`; drives GTX realign/slip
- `loss_sticky` out NLANES: set on the lane's `ALIGNED`→`REALIGN` transition
- `loss_count` out NLANES*CW: per-lane saturating count of loss events; lane i occupies bits [i*CW +: CW]

## Operation
- Each lane runs an independent 4-state FSM: `UNLOCKED`, `LOCKING`, `ALIGNED`, `REALIGN`.
- `UNLOCKED`: a comma without `code_err` → `LOCKING` with comma count = 1. When `LOCK_THRESHOLD` = 1, the lane goes directly to `ALIGNED` instead.
- `LOCKING`:
  - Each clean comma increments the comma count. The comma that brings the count to `LOCK_THRESHOLD` → `ALIGNED`.
  - Any `code_err` → `UNLOCKED`.
  - Miss counter reaching `MISS_THRESHOLD` → `UNLOCKED`.
- `ALIGNED`:
  - Miss counter reaching `MISS_THRESHOLD`, or error-run counter reaching `ERR_LIMIT` → `REALIGN`.
  - On that transition: `loss_sticky` is set and `loss_count` increments, saturating at 2^CW−1.
- `REALIGN`: `realign_req` is held for exactly `REALIGN_HOLD` cycles, then → `UNLOCKED`. Comma and error inputs are ignored during `REALIGN`.
- Miss counter:
  - Clears on any comma cycle.
  - Otherwise increments, saturating at `MISS_THRESHOLD`.
  - Cleared on every state change.
- Error-run counter:
  - Increments on each `code_err` cycle.
  - Clears on any cycle without `code_err`.
- Comma and `code_err` in the same cycle: counts as an error, not a comma. In that cycle the miss counter still clears.
- `sticky_clear` coinciding with a new loss on a lane: set wins; that lane's bit stays 1.
- Reset asserted mid-operation overrides everything on that edge: all lanes → `UNLOCKED`, all counters 0.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Lock latency: `aligned` rises on the edge that samples the `LOCK_THRESHOLD`-th clean comma.
- Loss latency: `aligned` falls on the same edge where `realign_req` rises. `loss_sticky` and `loss_count` update on that edge too.
- `realign_req` width is exactly `REALIGN_HOLD` cycles. `UNLOCKED` is entered on the following edge.
- `all_aligned` lags `aligned` by one cycle.
- The lanes share no state; there are no inter-lane dependencies except `all_aligned` and `sticky_clear`.

## Structure
- Shared package `gtx_align_pkg` holds the FSM state encoding, `UNLOCKED`=0, `LOCKING`=1, `ALIGNED`=2, `REALIGN`=3, and the `$clog2` counter-width helper constants.
- Sub-module `gtx_align_lane` holds one FSM plus its miss, comma, error-run, hold and loss counters. The top level is a generate loop over `NLANES` plus the `all_aligned` register.
- Counter widths:
  - miss: $clog2(MISS_THRESHOLD+1)
  - comma: $clog2(LOCK_THRESHOLD+1)
  - error-run: $clog2(ERR_LIMIT+1)
  - hold: $clog2(REALIGN_HOLD+1)

## Test plan
All tests use `NLANES`=2, `LOCK_THRESHOLD`=4, `MISS_THRESHOLD`=15, `ERR_LIMIT`=3, `REALIGN_HOLD`=5, `CW`=2.
- Lock: lane 0 gets a comma every 4th cycle → `aligned[0]`=1 on the edge of the 4th comma. `all_aligned` stays 0 while lane 1 is idle.
- Miss loss: both lanes aligned, then lane 1 commas stop → after 15 comma-free cycles:
  - `aligned[1]` falls.
  - `realign_req[1]` is high for exactly 5 cycles.
  - `loss_count[1]`=1 and `loss_sticky[1]`=1.
  - `all_aligned` falls one cycle after `aligned[1]`.
- Error run: aligned lane 0 gets 2 `code_err` cycles, then a clean cycle, then 2 more → no loss. 3 consecutive `code_err` cycles → loss.
- Lock abort: in `LOCKING` after 3 commas, a comma with `code_err` in the same cycle → `UNLOCKED`. 4 further clean commas are then needed to lock.
- Saturation and sticky: force 4 losses on lane 0 → `loss_count[0]`=3. `sticky_clear` on the same edge as a 5th loss → `loss_sticky[0]` stays 1.
- Reset mid-`REALIGN` → `realign_req`=0 and all outputs 0 on the next edge. Relock follows the normal 4-comma latency.
